// File: rtl/fetch_ifid_stage.sv
// RV32 instruction fetch plus IF/ID register, one outstanding imem request at a time.
// Optional macro FETCH_ILLEGAL_CHECK_EN adds the registered id_illegal opcode check.
module fetch_ifid_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic [6:0]      id_opcode,
  output logic            id_illegal,
  output logic [1:0]      dbg_state
);

  // imem handshake: a request transfers on a cycle with imem_req & imem_ready;
  // imem_addr holds until then. The response arrives as a single imem_rvalid pulse.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] hold_buf;
  logic [XLEN-1:0] load_word;
  logic            drop;
  logic            load_en;
  logic            req_accept;

  assign req_accept = (state == S_REQ) && imem_ready;
  assign imem_req   = (state == S_REQ) && !rst;
  assign imem_addr  = pc;
  assign id_opcode  = id_instr[6:0];
  assign dbg_state  = state;

  // IF/ID loads from the live response or from the hold buffer once decode frees up.
  always_comb begin
    load_en   = 1'b0;
    load_word = imem_rdata;
    if (!branch_taken && !stall) begin
      if (state == S_WAIT && imem_rvalid && !drop) begin
        load_en = 1'b1;
      end else if (state == S_HOLD) begin
        load_en   = 1'b1;
        load_word = hold_buf;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      hold_buf <= NOP;
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_instr <= NOP;
    end else if (branch_taken) begin
      pc       <= {branch_target[XLEN-1:2], 2'b00};
      id_valid <= 1'b0;
      // A request accepted earlier, or accepted in this very cycle, still owes a
      // response; wait for it and throw it away before fetching from the target.
      if ((state == S_WAIT && !imem_rvalid) || req_accept) begin
        drop  <= 1'b1;
        state <= S_WAIT;
      end else begin
        drop  <= 1'b0;
        state <= S_REQ;
      end
    end else begin
      if (load_en) begin
        id_valid <= 1'b1;
        id_pc    <= pc;
        id_instr <= load_word;
        pc       <= pc + XLEN'(4);
      end else if (!stall) begin
        id_valid <= 1'b0;
      end
      case (state)
        S_REQ: begin
          if (imem_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else if (stall) begin
              hold_buf <= imem_rdata;
              state    <= S_HOLD;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!stall) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

`ifdef FETCH_ILLEGAL_CHECK_EN
  logic illegal_q;

  function automatic logic opcode_unsupported(input logic [6:0] op);
    return !(op == 7'b0110011 || op == 7'b0000011 ||
             op == 7'b0100011 || op == 7'b1100011);
  endfunction

  // Follows id_valid: set on load, held on stall, cleared with the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (branch_taken) begin
      illegal_q <= 1'b0;
    end else if (load_en) begin
      illegal_q <= opcode_unsupported(load_word[6:0]);
    end else if (!stall) begin
      illegal_q <= 1'b0;
    end
  end

  assign id_illegal = illegal_q;
`else
  assign id_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Bench for fetch_ifid_stage: directed scenarios, then random traffic checked
// against a program-order model (expected PC stream, memory contents as a function).
module tb_fetch_ifid_stage;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [6:0]  id_opcode;
  logic        id_illegal;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;

  // memory model state
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_fix;
  logic        dir_mode;
  logic [31:0] dir_word;

  // scoreboard: program-order PCs still to be delivered to decode
  logic [31:0] exp_q[$];

  fetch_ifid_stage dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .id_instr     (id_instr),
    .id_opcode    (id_opcode),
    .id_illegal   (id_illegal),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (dir_mode) return dir_word;
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0033;
  endfunction

  function automatic logic exp_illegal(input logic [31:0] w);
`ifdef FETCH_ILLEGAL_CHECK_EN
    logic [6:0] op;
    op = w[6:0];
    return !(op == 7'b0110011 || op == 7'b0000011 ||
             op == 7'b0100011 || op == 7'b1100011);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: present the memory response, clock the DUT, then update the memory.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    imem_rvalid = mem_busy && (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? mem_word(mem_addr) : $urandom;
    hs = imem_req && imem_ready;
    a  = imem_addr;
    @(posedge clk);
    #1;
    if (imem_rvalid) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (hs) begin
      check("one_outstanding", 32'(mem_busy), 32'd0);
      mem_busy = 1'b1;
      mem_addr = a;
      mem_cnt  = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    stall        = 1'b0;
    branch_taken = 1'b0;
    imem_ready   = 1'b0;
    imem_rvalid  = 1'b0;
    mem_busy     = 1'b0;
    #1;
    check("rst_req",      32'(imem_req),   32'd0);
    check("rst_id_valid", 32'(id_valid),   32'd0);
    check("rst_id_pc",    id_pc,           32'd0);
    check("rst_id_instr", id_instr,        32'h0000_0013);
    check("rst_id_op",    32'(id_opcode),  32'h13);
    check("rst_illegal",  32'(id_illegal), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_req", 32'(imem_req), 32'd0);
    rst = 1'b0;
    #1;
    check("rel_req",  32'(imem_req), 32'd1);
    check("rel_addr", imem_addr,     32'd0);
  endtask

  initial begin
    logic        hold, h_v, br, prev_wait;
    logic [31:0] h_pc, h_i, tgt, prev_addr, e_pc, e_w;
    int          delivered;

    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0;
    lat_fix = 0; dir_mode = 1'b1; dir_word = 32'h00A0_0093;
    do_reset();

    // first fetch, zero-wait memory
    imem_ready = 1'b1;
    tick();
    check("first_wait_req", 32'(imem_req), 32'd0);
    check("first_wait_v",   32'(id_valid), 32'd0);
    tick();
    check("first_v",    32'(id_valid),  32'd1);
    check("first_pc",   id_pc,          32'd0);
    check("first_ins",  id_instr,       32'h00A0_0093);
    check("first_op",   32'(id_opcode), 32'h13);
    check("first_next", imem_addr,      32'd4);

    // decode stall across the response
    dir_word = 32'h0040_0113;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_v",   32'(id_valid), 32'd1);
      check("stall_pc",  id_pc,         32'd0);
      check("stall_ins", id_instr,      32'h00A0_0093);
      check("stall_adr", imem_addr,     32'd4);
    end
    stall = 1'b0;
    tick();
    check("unstall_v",   32'(id_valid), 32'd1);
    check("unstall_pc",  id_pc,         32'd4);
    check("unstall_ins", id_instr,      32'h0040_0113);
    check("unstall_adr", imem_addr,     32'd8);
    check("unstall_req", 32'(imem_req), 32'd1);

    // redirect while waiting; stale response two cycles later is discarded
    lat_fix = 2;
    dir_word = 32'hBADB_AD13;
    tick();
    check("bw_pre_v",   32'(id_valid), 32'd0);
    check("bw_pre_req", 32'(imem_req), 32'd0);
    branch_taken = 1'b1; branch_target = 32'h0000_0103;
    tick();
    branch_taken = 1'b0;
    check("bw_v",    32'(id_valid), 32'd0);
    check("bw_req",  32'(imem_req), 32'd0);
    check("bw_addr", imem_addr,     32'h100);
    tick();
    check("bw_wait_req", 32'(imem_req), 32'd0);
    tick();
    check("bw_drop_v",   32'(id_valid), 32'd0);
    check("bw_drop_req", 32'(imem_req), 32'd1);
    check("bw_drop_adr", imem_addr,     32'h100);
    lat_fix = 0;
    dir_word = 32'h0000_007F;
    tick();
    tick();
    check("bt_v",   32'(id_valid),   32'd1);
    check("bt_pc",  id_pc,           32'h100);
    check("bt_ins", id_instr,        32'h0000_007F);
    check("bt_ill", 32'(id_illegal), 32'(exp_illegal(32'h0000_007F)));

    // branch and stall together: branch wins
    imem_ready = 1'b0; stall = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h0000_0200;
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    check("bs_v",    32'(id_valid), 32'd0);
    check("bs_addr", imem_addr,     32'h200);
    check("bs_req",  32'(imem_req), 32'd1);

    // memory not ready: request and address hold
    for (int i = 0; i < 5; i++) begin
      tick();
      check("nr_req",  32'(imem_req), 32'd1);
      check("nr_addr", imem_addr,     32'h200);
    end
    imem_ready = 1'b1;
    dir_word = 32'h0020_8033;
    tick();
    tick();
    check("nr_pc",  id_pc,           32'h200);
    check("nr_ins", id_instr,        32'h0020_8033);
    check("nr_ill", 32'(id_illegal), 32'(exp_illegal(32'h0020_8033)));

    // pc wrap at the top of the address space
    imem_ready = 1'b0;
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
    tick();
    branch_taken = 1'b0;
    check("wrap_tgt", imem_addr, 32'hFFFF_FFFC);
    imem_ready = 1'b1;
    dir_mode = 1'b0;
    tick();
    tick();
    check("wrap_pc",   id_pc,     32'hFFFF_FFFC);
    check("wrap_ins",  id_instr,  mem_word(32'hFFFF_FFFC));
    check("wrap_next", imem_addr, 32'd0);

    // reset in the middle of an outstanding request
    lat_fix = 1;
    tick();
    check("mid_wait_req", 32'(imem_req), 32'd0);
    do_reset();

    // random traffic against the program-order model
    lat_fix = -1;
    dir_mode = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'd0);
    prev_wait = 1'b0;
    prev_addr = '0;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      stall        = ($urandom_range(0, 99) < 30);
      branch_taken = ($urandom_range(0, 99) < 6);
      branch_target = ($urandom_range(0, 3) == 0) ?
                      (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      imem_ready   = ($urandom_range(0, 99) < 70);

      if (prev_wait) begin
        check("stable_req",  32'(imem_req), 32'd1);
        check("stable_addr", imem_addr,     prev_addr);
      end
      if (imem_req) check("addr_align", 32'(imem_addr[1:0]), 32'd0);

      if (id_valid && !stall && !branch_taken) begin
        e_pc = exp_q.pop_front();
        e_w  = mem_word(e_pc);
        check("rnd_pc",  id_pc,           e_pc);
        check("rnd_ins", id_instr,        e_w);
        check("rnd_op",  32'(id_opcode),  32'(e_w[6:0]));
        check("rnd_ill", 32'(id_illegal), 32'(exp_illegal(e_w)));
        exp_q.push_back(e_pc + 32'd4);
        delivered++;
      end

      hold = stall && !branch_taken;
      h_v = id_valid; h_pc = id_pc; h_i = id_instr;
      prev_wait = imem_req && !imem_ready && !branch_taken;
      prev_addr = imem_addr;
      br  = branch_taken;
      tgt = {branch_target[31:2], 2'b00};

      tick();

      if (br) begin
        check("rnd_squash", 32'(id_valid), 32'd0);
        exp_q.delete();
        exp_q.push_back(tgt);
      end else if (hold) begin
        check("rnd_hold_v",   32'(id_valid), 32'(h_v));
        check("rnd_hold_pc",  id_pc,         h_pc);
        check("rnd_hold_ins", id_instr,      h_i);
      end
    end
    branch_taken = 1'b0;
    stall = 1'b0;
    check("rnd_progress", 32'(delivered > 200), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
